// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display constants and hex segment table
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Segment patterns {g,f,e,d,c,b,a}, active-low, indexed by nibble value
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/result_display_if.sv
// rtl/result_display_if.sv - ALU/loader side inputs and board pin outputs
interface result_display_if;

  logic        load;
  logic [15:0] data;
  logic [3:0]  flags;
  logic        blank;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic [3:0]  led;

  modport master (output load, data, flags, blank, input seg, an, dp, led);
  modport slave  (input load, data, flags, blank, output seg, an, dp, led);

endinterface

// File: rtl/result_display_hex7seg.sv
// rtl/result_display_hex7seg.sv - nibble to active-low seven-segment decoder
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_SEG[i_nibble];

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - captures ALU result/flags and scans a 4-digit hex display
module result_display
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  result_display_if.slave  bus
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);

  logic [15:0]      r_data;
  logic [3:0]       r_flag;
  logic             r_load_d;
  logic [CNT_W-1:0] r_div_cnt;
  logic [1:0]       r_idx;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;
  logic [3:0]       r_led;

  logic             w_capture;
  logic             w_div_wrap;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg;
  logic             w_upper_zero;
  logic [3:0]       w_an_scan;

  assign w_capture  = bus.load & ~r_load_d;
  assign w_div_wrap = (r_div_cnt == DIV_LAST);
  assign w_nibble   = r_data[{r_idx, 2'b00} +: 4];
  assign w_an_scan  = ~(4'b0001 << r_idx);

  // True when this digit and every more-significant digit are zero
  assign w_upper_zero = ((r_data >> {r_idx, 2'b00}) == 16'd0);

  hex7seg u_hex7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      r_flag    <= '0;
      r_load_d  <= 1'b0;
      r_div_cnt <= '0;
      r_idx     <= '0;
      r_seg     <= SEG_OFF;
      r_an      <= AN_OFF;
      r_led     <= '0;
    end else begin
      r_load_d <= bus.load;
      if (w_capture) begin
        r_data <= bus.data;
        r_flag <= bus.flags;
      end

      if (w_div_wrap) begin
        r_div_cnt <= '0;
        r_idx     <= r_idx + 2'd1;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end

      r_led <= r_flag;
      // Blanking only darkens the pins; the scan keeps running underneath
      if (bus.blank) begin
        r_seg <= SEG_OFF;
        r_an  <= AN_OFF;
      end else begin
        r_seg <= w_seg;
        r_an  <= (LZ_BLANK && w_upper_zero && (r_idx != 2'd0)) ? AN_OFF : w_an_scan;
      end
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;
  assign bus.dp  = 1'b1;
  assign bus.led = r_led;

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - randomized self-checking bench for result_display
module tb_result_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  flags = '0;
  logic        blank = 1'b0;

  always #5 clk = ~clk;

  result_display_if bus0 ();
  result_display_if bus1 ();

  assign bus0.load = load;  assign bus0.data = data;
  assign bus0.flags = flags; assign bus0.blank = blank;
  assign bus1.load = load;  assign bus1.data = data;
  assign bus1.flags = flags; assign bus1.blank = blank;

  result_display #(.SCAN_DIV(SD), .LZ_BLANK(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  result_display #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int failures = 0;

  logic [6:0] tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference: digit shown after edge k is floor(k/SD) mod 4 of the value captured before it
  int          m_k;
  int          m_idx;
  logic [15:0] m_data;
  logic [3:0]  m_flag;
  logic        m_load_d;
  logic [3:0]  m_nib;
  logic [6:0]  e_seg, e_seg_lz;
  logic [3:0]  e_an, e_an_lz, e_led;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k = 0; m_data = '0; m_flag = '0; m_load_d = 1'b0;
      e_seg = 7'h7F; e_seg_lz = 7'h7F; e_an = 4'hF; e_an_lz = 4'hF; e_led = '0;
    end else begin
      m_idx = (m_k / SD) % 4;
      m_nib = 4'(m_data >> (4 * m_idx));
      e_led = m_flag;
      if (blank) begin
        e_seg = 7'h7F; e_seg_lz = 7'h7F; e_an = 4'hF; e_an_lz = 4'hF;
      end else begin
        e_seg = tbl[m_nib];
        e_an = ~(4'b0001 << m_idx);
        e_seg_lz = e_seg;
        e_an_lz = (m_idx != 0 && (m_data >> (4 * m_idx)) == 16'd0) ? 4'hF : e_an;
      end
      if (load && !m_load_d) begin
        m_data = data;
        m_flag = flags;
      end
      m_load_d = load;
      m_k++;
    end
  end

  task automatic test_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus0.an, bus0.seg} !== {4'b1110, 7'b1000000}) begin
      failures++;
      $display("FAIL reset_first_edge an=%b seg=%b want an=1110 seg=1000000", bus0.an, bus0.seg);
    end
    @(negedge clk) begin data = 16'h9999; flags = 4'hF; load = 1'b1; end
    @(negedge clk) load = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus0.seg, bus0.an, bus0.led, bus0.dp} !== {7'b1111111, 4'b1111, 4'b0000, 1'b1}) begin
      failures++;
      $display("FAIL reset_async seg=%b an=%b led=%b dp=%b want 1111111 1111 0000 1", bus0.seg, bus0.an, bus0.led, bus0.dp);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus0.an, bus0.seg, bus0.led} !== {4'b1110, 7'b1000000, 4'b0000}) begin
      failures++;
      $display("FAIL reset_release an=%b seg=%b led=%b want 1110 1000000 0000", bus0.an, bus0.seg, bus0.led);
    end
  endtask

  task automatic test_capture_scan();
    @(negedge clk) begin data = 16'h12AF; flags = 4'b1010; load = 1'b1; end
    @(negedge clk) load = 1'b0;
    @(negedge clk);
    checks++;
    if (bus0.led !== 4'b1010) begin
      failures++;
      $display("FAIL capture_led led=%b want 1010", bus0.led);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checks++;
      if ({bus0.seg, bus0.an, bus0.led} !== {e_seg, e_an, e_led}) begin
        failures++;
        $display("FAIL capture_scan cyc=%0d seg=%b an=%b led=%b want %b %b %b", i, bus0.seg, bus0.an, bus0.led, e_seg, e_an, e_led);
      end
    end
  endtask

  task automatic test_held_load();
    @(negedge clk) begin data = 16'h0001; load = 1'b1; end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 4) data = 16'h0002;
      checks++;
      if ({bus0.seg, bus0.an} !== {e_seg, e_an} || (i > 1 && bus0.an == 4'b1110 && bus0.seg !== 7'b1111001)) begin
        failures++;
        $display("FAIL held_load cyc=%0d seg=%b an=%b want %b %b", i, bus0.seg, bus0.an, e_seg, e_an);
      end
    end
    load = 1'b0;
    @(negedge clk) load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus0.seg, bus0.an} !== {e_seg, e_an} || (i > 1 && bus0.an == 4'b1110 && bus0.seg !== 7'b0100100)) begin
        failures++;
        $display("FAIL reload cyc=%0d seg=%b an=%b want %b %b", i, bus0.seg, bus0.an, e_seg, e_an);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_blank();
    @(negedge clk) blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus0.an !== 4'b1111 || bus0.seg !== 7'b1111111) begin
        failures++;
        $display("FAIL blank cyc=%0d an=%b seg=%b want 1111 1111111", i, bus0.an, bus0.seg);
      end
    end
    blank = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({bus0.seg, bus0.an} !== {e_seg, e_an}) begin
        failures++;
        $display("FAIL blank_release cyc=%0d seg=%b an=%b want %b %b", i, bus0.seg, bus0.an, e_seg, e_an);
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    for (int v = 0; v < 2; v++) begin
      @(negedge clk) begin data = vals[v]; load = 1'b1; end
      @(negedge clk) load = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 18; i++) begin
        @(negedge clk);
        checks++;
        if ({bus1.seg, bus1.an} !== {e_seg_lz, e_an_lz} || bus1.an[3] !== 1'b1 || bus1.an[2] !== 1'b1
            || (v == 1 && bus1.an[1] !== 1'b1)
            || (bus1.an == 4'b1101 && bus1.seg !== 7'b0010010)
            || (bus1.an == 4'b1110 && bus1.seg !== 7'b1000000)) begin
          failures++;
          $display("FAIL lz_blank val=%h cyc=%0d seg=%b an=%b want %b %b", vals[v], i, bus1.seg, bus1.an, e_seg_lz, e_an_lz);
        end
      end
    end
  endtask

  task automatic test_reset_capture();
    @(negedge clk) begin data = 16'hBEEF; flags = 4'b0110; load = 1'b1; rst = 1'b0; end
    @(negedge clk) load = 1'b0;
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if ({bus0.seg, bus0.an, bus0.led} !== {e_seg, e_an, e_led} || bus0.led !== 4'b0000
          || bus0.seg !== 7'b1000000) begin
        failures++;
        $display("FAIL reset_capture cyc=%0d seg=%b an=%b led=%b want 1000000 %b 0000", i, bus0.seg, bus0.an, bus0.led, e_an);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if ({bus0.seg, bus0.an, bus0.led, bus0.dp} !== {e_seg, e_an, e_led, 1'b1}
          || {bus1.seg, bus1.an, bus1.led} !== {e_seg_lz, e_an_lz, e_led}) begin
        failures++;
        $display("FAIL random cyc=%0d seg=%b an=%b led=%b lz_seg=%b lz_an=%b want %b %b %b %b %b",
                 i, bus0.seg, bus0.an, bus0.led, bus1.seg, bus1.an, e_seg, e_an, e_led, e_seg_lz, e_an_lz);
      end
      load  = ($urandom_range(0, 2) == 0);
      data  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      flags = 4'($urandom);
      blank = ($urandom_range(0, 7) == 0);
    end
    load = 1'b0;
    blank = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_capture_scan();
    test_held_load();
    test_blank();
    test_lz_blank();
    test_reset_capture();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
- Output-side companion to the operand-loading state machine.
- Captures the ALU's 16-bit result and its four flags when the loader signals a step, and holds them.
- Drives the board's 4-digit multiplexed seven-segment display (hex) and the four flag LEDs.
- Sits between the ALU output / loader and the board I/O pins.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit stays lit (≥2).
- LZ_BLANK, 0, 1 = blank leading zero digits (digit 0 never blanked).

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- load  input  1  capture request (level); capture happens on its rising edge
- data  input  16  ALU result
- flags  input  4  {SF, OF, ZF, CF}
- blank  input  1  1 = all digits off
- seg  output  7  segment cathodes {g,f,e,d,c,b,a}, active-low
- an  output  4  digit anodes, active-low, one-hot-low; an[0] = rightmost digit
- dp  output  1  decimal point, active-low, held 1 (off)
- led  output  4  captured flags {SF, OF, ZF, CF}, active-high

Behaviour:
- Reset: rst, asynchronous, active-low; clock clk.
- Reset values: data_r=0, flag_r=0, load_d=0, div_cnt=0, idx=0, seg=7'b1111111, an=4'b1111, dp=1, led=0.
- Edge detect:
  - load_d <= load every cycle.
  - A capture occurs when load=1 and load_d=0.
  - On capture: data_r <= data, flag_r <= flags.
  - load held high captures exactly once; a new capture needs load to go low for at least one cycle.
- Scan:
  - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - On the cycle div_cnt==SCAN_DIV-1, idx <= idx+1 (2-bit, wraps 3→0).
- Digit select: nibble = data_r[4*idx+3 : 4*idx]; idx 0 → an[0].
- Output register (every clk):
  - an <= ~(4'b0001 << idx).
  - seg <= hex7seg(nibble).
  - led <= flag_r.
  - Display latency: 1 cycle from any idx or data_r change.
  - Capture-to-led latency: 2 cycles from the load rising edge.
- Blanking:
  - If blank=1: an <= 4'b1111 and seg <= 7'b1111111; the scan continues.
  - If LZ_BLANK=1 and every nibble at and above idx is 0 and idx≠0: that digit's an is forced high.
- Hex code table {g..a}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Boundary cases:
  - Reset mid-scan or mid-capture: immediate return to reset values; the captured value is lost.
  - First clock after reset release: an=4'b1110, seg=1000000 (digit 0 shows "0").
  - Capture on the same cycle as an idx wrap: both take effect; the next output register uses the new data_r and the new idx.
  - data changing while load stays high: ignored.

Decomposition:
- Shared package display_pkg:
  - SEG_OFF = 7'b1111111, AN_OFF = 4'b1111.
  - The 16-entry hex segment constant table.
- One natural sub-module: hex7seg (combinational, 4-bit nibble in, 7-bit seg out, uses the package table).
- Everything else (edge detect, divider, scan index, output registers, blanking) lives in result_display.

Test Plan (SCAN_DIV=4, LZ_BLANK=0 unless stated):
1. Reset:
   - Stimulus: assert rst low mid-run.
   - Required: seg=1111111, an=1111, led=0 asynchronously.
   - After release, first edge: an=1110, seg=1000000.
2. Capture and scan:
   - Stimulus: data=16'h12AF, flags=4'b1010, pulse load.
   - Required: 2 cycles later led=1010; digits scan in order F(0001110, an=1110), A(0001000, an=1101), 2(0100100, an=1011), 1(1111001, an=0111).
   - Each digit is held exactly 4 cycles; the sequence repeats.
3. Held load:
   - Stimulus: load high for 20 cycles while data changes 16'h0001→16'h0002.
   - Required: only 16'h0001 is displayed.
   - Then drop load for 1 cycle and re-raise it: 16'h0002 is displayed.
4. Blank:
   - Stimulus: blank=1 for 10 cycles.
   - Required: an=1111 throughout.
   - On release, the digit shown matches the free-running idx; no scan restart.
5. Leading-zero blanking:
   - Setup: LZ_BLANK=1, data=16'h0050.
   - Required: digits 3 and 2 dark (an bit high); digit 1 shows 5 (0010010); digit 0 shows 0 (1000000).
   - Setup: data=16'h0000.
   - Required: only digit 0 lit, showing "0".
6. Reset mid-capture:
   - Stimulus: drive rst low on the same cycle as a load rising edge.
   - Required: data_r stays 0.
   - After release, digit 0 displays 1000000.
